// File: rtl/mips_regfile_mp_if.sv
// Bus bundle for mips_regfile_mp: read/write ports, link port, ALU B operand and status.
// The master side drives addresses, write data and control; the slave side returns data and status.
interface mips_regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int IMM_W  = 16
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     we;
    logic [ADDR_W-1:0]        wa;
    logic [DATA_W-1:0]        wd;
    logic                     link_we;
    logic [DATA_W-1:0]        link_data;
    logic                     alu_src;
    logic [IMM_W-1:0]         imm;
    logic [DATA_W-1:0]        op_b;
    logic                     clr_req;
    logic                     ready;
    logic                     wr_drop;

    modport master (
        output rd_addr, we, wa, wd, link_we, link_data, alu_src, imm, clr_req,
        input  rd_data, op_b, ready, wr_drop
    );

    modport slave (
        input  rd_addr, we, wa, wd, link_we, link_data, alu_src, imm, clr_req,
        output rd_data, op_b, ready, wr_drop
    );
endinterface

// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS register file with link port, hardwired r0, post-reset clear sweep and ALU B mux.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module mips_regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int IMM_W    = 16,
    parameter int LINK_REG = 31
) (
    input logic              clk,
    input logic              rst,
    mips_regfile_mp_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    if (NUM_RD < 2 || NUM_RD > 4) begin : g_bad_num_rd
        $error("mips_regfile_mp: NUM_RD must be in 2..4");
    end
    if (LINK_REG >= DEPTH) begin : g_bad_link_reg
        $error("mips_regfile_mp: LINK_REG must be below DEPTH");
    end

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              ready_q, ready_d;
    logic              wr_drop_q, wr_drop_d;

    // No reset on the array so it can map to plain RAM; the sweep zeroes it instead.
    logic [DATA_W-1:0] mem [DEPTH];

    logic gen_wr;
    logic link_wr;
    assign gen_wr  = (state_q == IDLE) && bus.we && (bus.wa != '0);
    assign link_wr = (state_q == IDLE) && bus.link_we && (LINK_ADDR != '0);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ready_d   = ready_q;
        wr_drop_d = 1'b0;
        case (state_q)
            CLEAR: begin
                idx_d     = idx_q + ADDR_W'(1);
                wr_drop_d = (bus.we && (bus.wa != '0)) || bus.link_we;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            IDLE: begin
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    idx_d   = ADDR_W'(1);
                    ready_d = 1'b0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            idx_q     <= ADDR_W'(1);
            ready_q   <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ready_q   <= ready_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Link write comes second so it wins when both ports target LINK_REG.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem[idx_q] <= '0;
            end else begin
                if (gen_wr)  mem[bus.wa]   <= bus.wd;
                if (link_wr) mem[LINK_ADDR] <= bus.link_data;
            end
        end
    end

    logic [NUM_RD*DATA_W-1:0] rd_flat;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] val;
        assign addr = bus.rd_addr[gi*ADDR_W +: ADDR_W];
        always_comb begin
            val = mem[addr];
`ifdef REGFILE_BYPASS_EN
            if (link_wr && (addr == LINK_ADDR)) begin
                val = bus.link_data;
            end else if (gen_wr && (addr == bus.wa)) begin
                val = bus.wd;
            end
`endif
            if ((addr == '0) || (state_q == CLEAR)) begin
                val = '0;
            end
        end
        assign rd_flat[gi*DATA_W +: DATA_W] = val;
    end

    assign bus.rd_data = rd_flat;
    assign bus.op_b    = bus.alu_src ? {{(DATA_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm}
                                     : rd_flat[DATA_W +: DATA_W];
    assign bus.ready   = ready_q;
    assign bus.wr_drop = wr_drop_q;
endmodule

// File: tb/tb_mips_regfile_mp.sv
// Directed self-checking bench for mips_regfile_mp (default parameters, two read ports).
// Expected values are hand-computed; the bypass step expects differently per REGFILE_BYPASS_EN.
module tb_mips_regfile_mp;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    int   cnt;

    mips_regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .IMM_W(16)) bus ();

    mips_regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .IMM_W(16), .LINK_REG(31)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        bus.rd_addr = {a1, a0};
        #1;
    endtask

    task automatic wait_ready();
        cnt = 0;
        while (bus.ready !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.rd_addr = '0; bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
        bus.link_we = 1'b0; bus.link_data = '0; bus.alu_src = 1'b0;
        bus.imm = '0; bus.clr_req = 1'b0;

        // Reset and initial sweep
        tick();
        rst = 1'b0;
        check("reset_ready", 32'(bus.ready), 32'd0);
        check("reset_wr_drop", 32'(bus.wr_drop), 32'd0);
        wait_ready();
        check("sweep_len", 32'(cnt), 32'd31);
        for (int i = 0; i < 32; i++) begin
            set_rd(5'(i), 5'(31 - i));
            check($sformatf("clear_p0_r%0d", i), bus.rd_data[31:0], 32'h0);
            check($sformatf("clear_p1_r%0d", 31 - i), bus.rd_data[63:32], 32'h0);
        end
        $display("txn reset sweep: %0d cycles", cnt);

        // Basic write/read
        bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'hDEADBEEF;
        tick();
        bus.we = 1'b0;
        set_rd(5'd5, 5'd0);
        check("wr5_p0", bus.rd_data[31:0], 32'hDEADBEEF);
        check("rd0_p1", bus.rd_data[63:32], 32'h0);
        $display("txn write r5=0xDEADBEEF");

        // Write to r0 is ignored without a drop pulse
        bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'h1234;
        tick();
        bus.we = 1'b0;
        check("wr0_drop", 32'(bus.wr_drop), 32'd0);
        set_rd(5'd0, 5'd5);
        check("wr0_read", bus.rd_data[31:0], 32'h0);
        check("wr0_r5_kept", bus.rd_data[63:32], 32'hDEADBEEF);
        $display("txn write r0 ignored");

        // Both ports target r31: link wins
        bus.we = 1'b1; bus.wa = 5'd31; bus.wd = 32'h1111;
        bus.link_we = 1'b1; bus.link_data = 32'h00400008;
        tick();
        bus.we = 1'b0; bus.link_we = 1'b0;
        check("link_prio_drop", 32'(bus.wr_drop), 32'd0);
        set_rd(5'd31, 5'd0);
        check("link_prio_r31", bus.rd_data[31:0], 32'h00400008);
        $display("txn dual write r31, link priority");

        // Dual write to distinct registers
        bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'h22;
        bus.link_we = 1'b1; bus.link_data = 32'h00400010;
        tick();
        bus.we = 1'b0; bus.link_we = 1'b0;
        set_rd(5'd7, 5'd31);
        check("dual_r7", bus.rd_data[31:0], 32'h22);
        check("dual_r31", bus.rd_data[63:32], 32'h00400010);
        $display("txn dual write r7 and r31");

        // Immediate mux
        bus.alu_src = 1'b1; bus.imm = 16'h8001; #1;
        check("imm_neg", bus.op_b, 32'hFFFF8001);
        bus.imm = 16'h7FFF; #1;
        check("imm_pos", bus.op_b, 32'h00007FFF);
        bus.alu_src = 1'b0;
        bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'hA5A5A5A5;
        tick();
        bus.we = 1'b0;
        set_rd(5'd0, 5'd5);
        check("opb_reg", bus.op_b, 32'hA5A5A5A5);
        $display("txn op_b imm/reg mux");

        // Same-cycle write then read
        bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'h10;
        tick();
        bus.wd = 32'h20;
        set_rd(5'd9, 5'd9);
`ifdef REGFILE_BYPASS_EN
        check("bypass_pre_p0", bus.rd_data[31:0], 32'h20);
        check("bypass_pre_opb", bus.op_b, 32'h20);
`else
        check("bypass_pre_p0", bus.rd_data[31:0], 32'h10);
        check("bypass_pre_opb", bus.op_b, 32'h10);
`endif
        tick();
        bus.we = 1'b0; #1;
        check("bypass_post_p0", bus.rd_data[31:0], 32'h20);
        $display("txn same-cycle write/read r9");

        // Clear request, then dropped writes during the sweep
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0; #1;
        check("clr_ready", 32'(bus.ready), 32'd0);
        set_rd(5'd9, 5'd5);
        check("clr_read_zero", bus.rd_data[31:0], 32'h0);
        check("clr_opb_zero", bus.op_b, 32'h0);
        tick();
        bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'd9;
        tick();
        bus.we = 1'b0;
        check("drop_pulse", 32'(bus.wr_drop), 32'd1);
        tick();
        check("drop_end", 32'(bus.wr_drop), 32'd0);
        bus.we = 1'b1; bus.wa = 5'd0;
        tick();
        bus.we = 1'b0;
        check("drop_wa0", 32'(bus.wr_drop), 32'd0);
        bus.link_we = 1'b1;
        tick();
        bus.link_we = 1'b0;
        check("drop_link", 32'(bus.wr_drop), 32'd1);
        wait_ready();
        check("clr_ready_back", 32'(bus.ready), 32'd1);
        set_rd(5'd3, 5'd5);
        check("clr_r3", bus.rd_data[31:0], 32'h0);
        check("clr_r5", bus.rd_data[63:32], 32'h0);
        set_rd(5'd31, 5'd9);
        check("clr_r31", bus.rd_data[31:0], 32'h0);
        check("clr_r9", bus.rd_data[63:32], 32'h0);
        $display("txn clear sweep with dropped writes");

        // Reset mid-sweep restarts from idx 1
        bus.we = 1'b1; bus.wa = 5'd12; bus.wd = 32'hCAFE;
        tick();
        bus.we = 1'b0;
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready();
        check("rst_mid_sweep_len", 32'(cnt), 32'd31);
        set_rd(5'd12, 5'd7);
        check("rst_mid_r12", bus.rd_data[31:0], 32'h0);
        check("rst_mid_r7", bus.rd_data[63:32], 32'h0);
        $display("txn reset mid-sweep: %0d cycles", cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_regfile_mp.md
Name: mips_regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the single-cycle/pipelined MIPS datapath.
- Replaces the fixed 2-read/1-write array. Adds:
  - synchronous writes;
  - a dedicated link-register write port for JAL;
  - a hardwired zero register;
  - a sequenced clear sweep after reset, so the array can map to reset-less RAM.
- Also produces the ALU B operand: register value or sign-extended immediate.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W.
- NUM_RD, 2, number of read ports (legal range 2..4).
- IMM_W, 16, immediate width; sign-extended to DATA_W.
- LINK_REG, 31, register index written by the link port.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way.
- we  in  1  general write enable.
- wa  in  ADDR_W  general write address.
- wd  in  DATA_W  general write data.
- link_we  in  1  link write enable.
- link_data  in  DATA_W  return address to write into LINK_REG.
- alu_src  in  1  0: op_b = read port 1; 1: op_b = sign-extended imm.
- imm  in  IMM_W  instruction immediate.
- op_b  out  DATA_W  ALU B operand.
- clr_req  in  1  one-cycle request to re-run the clear sweep.
- ready  out  1  high when the file accepts writes and returns valid reads.
- wr_drop  out  1  one-cycle pulse: a write request was discarded.

Behaviour:
- States: CLEAR, IDLE. A sweep counter `idx` is ADDR_W bits wide.
- Reset (rst=1 at a clock edge):
  - state<=CLEAR, idx<=1, ready<=0, wr_drop<=0.
  - Array contents are not reset directly.
- CLEAR state:
  - Each cycle writes 0 to reg[idx], then idx<=idx+1.
  - When idx==DEPTH-1 is written: state<=IDLE, ready<=1 on the next edge. Sweep length is DEPTH-1 cycles (31 at default).
  - All rd_data and the register path of op_b read 0.
  - we/link_we requests are discarded; wr_drop<=1 for each edge where (we&&wa!=0)||link_we.
  - clr_req is ignored.
- IDLE state:
  - clr_req=1 at an edge: state<=CLEAR, idx<=1, ready<=0. Any write in that same edge is still performed.
- Reads:
  - Combinational from the array.
  - rd_addr==0 always returns 0.
  - Read latency 0; the new value is visible after the write edge.
- Writes (IDLE only), at the rising edge:
  - we=1, wa!=0: reg[wa]<=wd.
  - wa==0: silently ignored; no wr_drop.
  - link_we=1: reg[LINK_REG]<=link_data.
  - Both writes in one cycle to different addresses: both take effect.
  - Both target LINK_REG: link_data wins; no wr_drop.
- Reg 0 is never written, including by the sweep, and always reads 0.
- op_b:
  - alu_src=0: rd_data port 1.
  - alu_src=1: {(DATA_W-IMM_W){imm[IMM_W-1]}, imm}.
  - Purely combinational.
- wr_drop is a registered pulse, low in every cycle with no dropped write.
- Reset mid-sweep or mid-operation restarts the sweep from idx=1. rst has priority over clr_req and writes.
- Out-of-range parameters: NUM_RD<2 or >4, or LINK_REG>=DEPTH, fail at elaboration via a generate-time error.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding in IDLE.
  - Any read port whose address equals a same-cycle active write address (nonzero) returns the incoming data combinationally.
  - link_data has priority when both writes hit LINK_REG.
  - op_b follows port 1's bypassed value.
- Not defined: reads return the pre-edge array value; the written value appears after the edge.

Test Plan:
- Reset sweep:
  - Assert rst 1 cycle, then hold idle inputs.
  - ready=0 for exactly 31 cycles, then 1.
  - All 32 registers read 0 afterwards.
- Basic write/read, two ports:
  - we=1, wa=5, wd=0xDEADBEEF.
  - Next cycle rd_addr0=5 -> 0xDEADBEEF.
  - rd_addr1=0 -> 0.
  - Write wa=0, wd=0x1234 -> reg0 still reads 0, wr_drop=0.
- Dual write and link priority:
  - Same edge: we=1, wa=31, wd=0x1111 and link_we=1, link_data=0x00400008 -> reg31=0x00400008.
  - Same edge: wa=7, wd=0x22 with link write -> reg7=0x22, reg31=link_data.
- Dropped writes during sweep:
  - clr_req in IDLE, then we=1, wa=3, wd=9 two cycles later -> wr_drop pulses 1 cycle.
  - reg3 reads 0 after ready returns.
- Immediate mux:
  - alu_src=1, imm=0x8001 -> op_b=0xFFFF8001.
  - imm=0x7FFF -> 0x00007FFF.
  - alu_src=0, rd_addr1=5 holding 0xA5A5A5A5 -> op_b=0xA5A5A5A5.
- Bypass (with and without REGFILE_BYPASS_EN):
  - reg9=0x10; same cycle we=1, wa=9, wd=0x20, rd_addr0=9.
  - Before the edge rd_data0=0x20 when defined, 0x10 when undefined.
  - After the edge 0x20 in both builds.
